// File: rtl/join_unit_if.sv
// -----------------------------------------------------------------------------
// join_unit_if
// Purpose : bundles the per-core instruction / enable / status signals that
//           connect the join unit to the core array and the fork unit.
// Signals :
//   ins_in        NCORES*16  current instruction per core (core i at [16i+15:16i])
//   ins_valid     NCORES     slice i is being executed this cycle
//   core_ens_in   NCORES     enable vector from the fork unit
//   core_ens_out  NCORES     registered enable vector with halted cores cleared
//   core_stall    NCORES     core i holds its PC (waiting in a JOIN)
//   halt_pulse    NCORES     one-cycle pulse per halted core
//   join_done     NCORES     one-cycle pulse per released JOIN
//   join_timeout  NCORES     one-cycle pulse per JOIN released by the watchdog
// Modports: master = core array / fork side, slave = join unit.
// -----------------------------------------------------------------------------
interface join_unit_if #(
    parameter int NCORES = 4
) ();
    logic [NCORES*16-1:0] ins_in;
    logic [NCORES-1:0]    ins_valid;
    logic [NCORES-1:0]    core_ens_in;
    logic [NCORES-1:0]    core_ens_out;
    logic [NCORES-1:0]    core_stall;
    logic [NCORES-1:0]    halt_pulse;
    logic [NCORES-1:0]    join_done;
    logic [NCORES-1:0]    join_timeout;

    modport master (
        output ins_in, ins_valid, core_ens_in,
        input  core_ens_out, core_stall, halt_pulse, join_done, join_timeout
    );

    modport slave (
        input  ins_in, ins_valid, core_ens_in,
        output core_ens_out, core_stall, halt_pulse, join_done, join_timeout
    );
endinterface

// File: rtl/join_unit.sv
// -----------------------------------------------------------------------------
// join_unit
// Purpose : handles HALT and JOIN instructions for an array of NCORES cores.
//           HALT clears the issuing core's enable bit; JOIN stalls the issuing
//           core until every other enabled core has halted or is itself
//           waiting in a JOIN. Simultaneous releases are serialised lowest
//           index first.
// Ports   :
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    join_unit_if.slave (instruction, enable and status vectors)
// Config  : define JOIN_TIMEOUT_EN to add a 16-bit watchdog per core that
//           force-releases a JOIN after JOIN_TIMEOUT cycles in WAIT. Without
//           it no counters exist and join_timeout is constant 0.
// -----------------------------------------------------------------------------
module join_unit #(
    parameter int          NCORES       = 4,
    parameter logic [3:0]  HALT         = 4'hF,
    parameter logic [3:0]  JOIN         = 4'h7,
    parameter logic [15:0] JOIN_TIMEOUT = 16'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    join_unit_if.slave  bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q [NCORES];
    logic              armed_q;      // low on the first edge after reset release
    logic [NCORES-1:0] ens_out_q;
    logic [NCORES-1:0] halt_q;
    logic [NCORES-1:0] done_q;
    logic [NCORES-1:0] pend_q;       // released-eligible cores still queued

    logic [NCORES-1:0] wait_vec;
    logic [NCORES-1:0] accept;
    logic [NCORES-1:0] halt_acc;
    logic [NCORES-1:0] join_acc;
    logic [NCORES-1:0] live;
    logic [NCORES-1:0] cond_ok;
    logic [NCORES-1:0] eligible;
    logic [NCORES-1:0] grant;
    logic [NCORES-1:0] fire;
    logic [NCORES-1:0] release_vec;
    logic [NCORES-1:0] ens_out_d;
    logic [NCORES-1:0] pend_d;
    logic [NCORES*12-1:0] ins_low;
    logic              unused_ins;

    // A core blocks others' release while it is enabled, running and not
    // halting this very cycle.
    assign live = bus.core_ens_in & ~halt_acc & ~wait_vec;

    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
            assign wait_vec[gi] = (state_q[gi] == ST_WAIT);
            assign accept[gi]   = armed_q & bus.ins_valid[gi]
                                & bus.core_ens_in[gi] & ~wait_vec[gi];
            assign halt_acc[gi] = accept[gi] & (bus.ins_in[16*gi+12 +: 4] == HALT);
            assign join_acc[gi] = accept[gi] & (bus.ins_in[16*gi+12 +: 4] == JOIN);
            // Release condition: no other core is live.
            assign cond_ok[gi]  = ~|(live & ~(NCORES'(1) << gi));
            assign ins_low[12*gi +: 12] = bus.ins_in[16*gi +: 12];
        end
    endgenerate

    // Operand bits are irrelevant here; only the opcode nibble is decoded.
    assign unused_ins = ^ins_low;

    // A core that qualified once stays qualified (pend_q) until its turn, so
    // the ascending-order release is not undone by an earlier core resuming.
    assign eligible    = wait_vec & bus.core_ens_in & (cond_ok | pend_q);
    assign grant       = eligible & (~eligible + NCORES'(1));
    assign release_vec = grant | fire;
    assign pend_d      = eligible & ~release_vec;
    assign ens_out_d   = bus.core_ens_in & ~halt_acc;

`ifdef JOIN_TIMEOUT_EN
    logic [15:0]       cnt_q [NCORES];
    logic [NCORES-1:0] timeout_q;

    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_wdog
            assign fire[gi] = wait_vec[gi] & bus.core_ens_in[gi]
                            & (cnt_q[gi] == JOIN_TIMEOUT);
        end
    endgenerate

    assign bus.join_timeout = timeout_q;
`else
    logic unused_timeout;

    assign fire             = '0;
    assign unused_timeout   = ^JOIN_TIMEOUT;
    assign bus.join_timeout = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q   <= 1'b0;
            ens_out_q <= NCORES'(1);
            halt_q    <= '0;
            done_q    <= '0;
            pend_q    <= '0;
            for (int i = 0; i < NCORES; i++) begin
                state_q[i] <= ST_RUN;
`ifdef JOIN_TIMEOUT_EN
                cnt_q[i]   <= '0;
`endif
            end
`ifdef JOIN_TIMEOUT_EN
            timeout_q <= '0;
`endif
        end else begin
            armed_q   <= 1'b1;
            ens_out_q <= ens_out_d;
            halt_q    <= halt_acc;
            done_q    <= release_vec;
            pend_q    <= pend_d;
`ifdef JOIN_TIMEOUT_EN
            timeout_q <= fire;
`endif
            for (int i = 0; i < NCORES; i++) begin
                case (state_q[i])
                    ST_RUN: begin
                        if (join_acc[i]) begin
                            state_q[i] <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        // Losing the enable abandons the join silently.
                        if (!bus.core_ens_in[i] || release_vec[i]) begin
                            state_q[i] <= ST_RUN;
                        end
                    end
                    default: state_q[i] <= ST_RUN;
                endcase
`ifdef JOIN_TIMEOUT_EN
                // Held at zero while running so it reads 0 on WAIT entry.
                if (state_q[i] == ST_RUN) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
`endif
            end
        end
    end

    assign bus.core_ens_out = ens_out_q;
    assign bus.core_stall   = wait_vec;
    assign bus.halt_pulse   = halt_q;
    assign bus.join_done    = done_q;

endmodule

// File: tb/tb_join_unit.sv
// -----------------------------------------------------------------------------
// tb_join_unit
// Purpose : self-checking bench for join_unit (NCORES = 4). Directed scenarios
//           followed by randomized instruction streams, all compared every
//           cycle against a cycle-level reference model of the HALT/JOIN rules.
// -----------------------------------------------------------------------------
module tb_join_unit;

    localparam int         N       = 4;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JOIN = 4'h7;
`ifdef JOIN_TIMEOUT_EN
    localparam logic [15:0] LIMIT  = 16'd10;
`else
    localparam logic [15:0] LIMIT  = 16'd255;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    join_unit_if #(.NCORES(N)) bus ();

    join_unit #(
        .NCORES       (N),
        .HALT         (OP_HALT),
        .JOIN         (OP_JOIN),
        .JOIN_TIMEOUT (LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model state: what the outputs must show after the next edge.
    bit [N-1:0] m_wait, m_pend, m_ens_out, m_halt, m_done, m_to;
    bit         m_armed;
    int         m_cnt [N];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_wait = '0; m_pend = '0; m_halt = '0; m_done = '0; m_to = '0;
        m_ens_out = N'(1);
        m_armed = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // Apply the HALT/JOIN rules for one clock edge with the given inputs.
    task automatic model_step(input bit [N-1:0] v, input logic [63:0] ins, input bit [N-1:0] ens);
        bit [N-1:0] h, jn, elig, rel, fire, nwait;
        int first;
        h = '0; jn = '0; elig = '0; rel = '0; fire = '0; nwait = '0;
        for (int i = 0; i < N; i++) begin
            if (m_armed && v[i] && ens[i] && !m_wait[i]) begin
                if (ins[16*i+12 +: 4] == OP_HALT) h[i] = 1'b1;
                if (ins[16*i+12 +: 4] == OP_JOIN) jn[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_wait[i] && ens[i]) begin
                bit free_all;
                free_all = 1'b1;
                for (int j = 0; j < N; j++)
                    if (j != i && ens[j] && !h[j] && !m_wait[j]) free_all = 1'b0;
                if (free_all || m_pend[i]) elig[i] = 1'b1;
`ifdef JOIN_TIMEOUT_EN
                if (m_cnt[i] == int'(LIMIT)) fire[i] = 1'b1;
`endif
            end
        end
        first = -1;
        for (int i = 0; i < N; i++)
            if (elig[i] && first < 0) first = i;
        if (first >= 0) rel[first] = 1'b1;
        rel = rel | fire;
        for (int i = 0; i < N; i++) begin
            if (m_wait[i]) begin
                nwait[i] = ens[i] && !rel[i];
                m_cnt[i] = m_cnt[i] + 1;
            end else begin
                nwait[i] = jn[i];
                m_cnt[i] = 0;
            end
        end
        m_pend    = elig & ~rel;
        m_wait    = nwait;
        m_done    = rel;
        m_to      = fire;
        m_halt    = h;
        m_ens_out = ens & ~h;
        m_armed   = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ens_out"}, 16'(bus.core_ens_out), 16'(m_ens_out));
        check({tag, ".stall"},   16'(bus.core_stall),   16'(m_wait));
        check({tag, ".halt"},    16'(bus.halt_pulse),   16'(m_halt));
        check({tag, ".done"},    16'(bus.join_done),    16'(m_done));
        check({tag, ".timeout"}, 16'(bus.join_timeout), 16'(m_to));
    endtask

    // Called at a falling edge: drive, advance one clock, check at next fall.
    task automatic step(input string tag, input logic [N-1:0] v, input logic [15:0] ops,
                        input logic [N-1:0] ens);
        logic [63:0] ins;
        for (int i = 0; i < N; i++) ins[16*i +: 16] = {ops[4*i +: 4], 12'($urandom)};
        bus.ins_valid   = v;
        bus.ins_in      = ins;
        bus.core_ens_in = ens;
        model_step(v, ins, ens);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, '0, 16'h0000, m_ens_out);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, ".rst_stall"}, 16'(bus.core_stall),   16'h0000);
        check({tag, ".rst_ens"},   16'(bus.core_ens_out), 16'h0001);
        check({tag, ".rst_done"},  16'(bus.join_done),    16'h0000);
        check({tag, ".rst_halt"},  16'(bus.halt_pulse),   16'h0000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rand_op();
        int r;
        logic [3:0] o;
        r = int'($urandom_range(0, 5));
        if (r == 0) return OP_HALT;
        if (r <= 2) return OP_JOIN;
        o = 4'($urandom_range(0, 13));
        if (o >= 4'h7) o = o + 4'h1;   // skip JOIN opcode; 0xF never reached
        return o;
    endfunction

    initial begin
        bus.ins_valid   = '0;
        bus.ins_in      = '0;
        bus.core_ens_in = '0;
        model_reset();
        @(negedge clk);
        do_reset("init");

        // Single HALT on core 1.
        step("h_arm", 4'b0000, 16'h0000, 4'b0011);
        step("h_go",  4'b0010, 16'h00F0, 4'b0011);
        check("halt1_ens",   16'(bus.core_ens_out), 16'h0001);
        check("halt1_pulse", 16'(bus.halt_pulse),   16'h0002);
        idle("h_after", 1);
        check("halt1_once",  16'(bus.halt_pulse),   16'h0000);

        // JOIN on core 0 released only after cores 1 and 2 halt.
        step("j3_join", 4'b0001, 16'h0007, 4'b0111);
        idle("j3_wait", 6);
        step("j3_h1", 4'b0010, 16'h00F0, m_ens_out);
        idle("j3_wait2", 9);
        check("j3_stall", 16'(bus.core_stall), 16'h0001);
        step("j3_h2", 4'b0100, 16'h0F00, m_ens_out);
        check("j3_done", 16'(bus.join_done), 16'h0001);
        idle("j3_after", 1);

        // Two JOINs released one per cycle, lowest index first.
        step("j4_join", 4'b0101, 16'h0707, 4'b1111);
        idle("j4_wait", 4);
        step("j4_halt", 4'b1010, 16'hF0F0, m_ens_out);
        check("j4_done0", 16'(bus.join_done), 16'h0001);
        idle("j4_next", 1);
        check("j4_done2", 16'(bus.join_done), 16'h0004);
        idle("j4_after", 1);

        // Ignored HALTs: disabled core 3, stalled core 0.
        step("ig_dis", 4'b1000, 16'hF000, 4'b0001);
        check("ig_dis_pulse", 16'(bus.halt_pulse), 16'h0000);
        step("ig_join", 4'b0001, 16'h0007, 4'b0011);
        step("ig_stl", 4'b0001, 16'h000F, 4'b0011);
        check("ig_stl_pulse", 16'(bus.halt_pulse),   16'h0000);
        check("ig_stl_ens",   16'(bus.core_ens_out), 16'h0003);
        step("ig_rel", 4'b0010, 16'h00F0, 4'b0011);
        check("ig_rel_done",  16'(bus.join_done), 16'h0001);
        idle("ig_after", 1);

        // JOIN alone: one cycle in WAIT, done two cycles after issue.
        step("solo_join", 4'b0001, 16'h0007, 4'b0001);
        check("solo_stall", 16'(bus.core_stall), 16'h0001);
        idle("solo_rel", 1);
        check("solo_done", 16'(bus.join_done), 16'h0001);

`ifdef JOIN_TIMEOUT_EN
        // Watchdog: core 1 never halts.
        step("wd_join", 4'b0001, 16'h0007, 4'b0011);
        idle("wd_wait", 10);
        check("wd_early", 16'(bus.join_done), 16'h0000);
        idle("wd_fire", 1);
        check("wd_done", 16'(bus.join_done),    16'h0001);
        check("wd_to",   16'(bus.join_timeout), 16'h0001);
`endif

        // Reset while core 0 waits: pending join is discarded.
        step("rw_join", 4'b0001, 16'h0007, 4'b0011);
        idle("rw_wait", 2);
        do_reset("rw");
        idle("rw_after", 4);
        check("rw_no_done", 16'(bus.join_done), 16'h0000);

        // Randomized streams with fork-unit feedback.
        for (int it = 0; it < 600; it++) begin
            logic [N-1:0] ens;
            logic [15:0]  ops;
            ens = m_ens_out;
            if ($urandom_range(0, 7) == 0)  ens[$urandom_range(0, N-1)] = 1'b1;
            if ($urandom_range(0, 24) == 0) ens[$urandom_range(0, N-1)] = 1'b0;
            if (ens == '0) ens = N'(1);
            for (int i = 0; i < N; i++) ops[4*i +: 4] = rand_op();
            if (it == 300) do_reset("rnd_rst");
            step("rnd", N'($urandom), ops, ens);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
